// File: rtl/bmem_arbiter.sv
// rtl/bmem_arbiter.sv - I/D cache front end arbitrating cacheline reads/writes onto banked memory
// Optional feature: define BMEM_ARB_RR_EN for round-robin arbitration between the I and D ports.
module bmem_arbiter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 i_addr,
  input  logic                        i_read,
  output logic                        i_accept,
  output logic                        i_rvalid,
  output logic [BEAT_W-1:0]           i_rdata,
  input  logic [31:0]                 d_addr,
  input  logic                        d_read,
  input  logic                        d_write,
  input  logic [BEAT_W*BURST_LEN-1:0] d_wdata,
  output logic                        d_accept,
  output logic                        d_wdone,
  output logic                        d_rvalid,
  output logic [BEAT_W-1:0]           d_rdata,
  output logic [31:0]                 bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [31:0]                 bmem_raddr,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid,
  output logic                        err
);

  localparam int LINE_W = BEAT_W * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam int LA_W   = 27;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  state_e            state_q, state_d;
  logic              i_pend_q, i_pend_d, d_pend_q, d_pend_d;
  logic [LA_W-1:0]   i_line_q, i_line_d, d_line_q, d_line_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [CNT_W-1:0]  wbeat_q, wbeat_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LA_W-1:0]   waddr_q, waddr_d;
  logic              d_older_q, d_older_d;
  logic              err_q, err_d;
`ifdef BMEM_ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  logic i_elig, d_elig, grant_i, grant_d;
  logic hit_i, hit_d, route_i, route_d;

  // Line offset bits never take part in arbitration or routing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0], bmem_raddr[4:0]};

  // Next-state for arbitration, write serialization and read-beat routing; outputs forced low in reset.
  always_comb begin
    state_d   = state_q;
    i_pend_d  = i_pend_q;
    d_pend_d  = d_pend_q;
    i_line_d  = i_line_q;
    d_line_d  = d_line_q;
    i_cnt_d   = i_cnt_q;
    d_cnt_d   = d_cnt_q;
    wbeat_d   = wbeat_q;
    wline_d   = wline_q;
    waddr_d   = waddr_q;
    d_older_d = d_older_q;
    err_d     = err_q;
`ifdef BMEM_ARB_RR_EN
    last_d_d  = last_d_q;
`endif
    i_accept   = 1'b0;
    d_accept   = 1'b0;
    d_wdone    = 1'b0;
    bmem_addr  = 32'h0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    i_rdata    = bmem_rdata;
    d_rdata    = bmem_rdata;
    err        = err_q;

    // Eligibility looks only at registered pend flags, so a port freed this cycle waits one cycle.
    i_elig  = i_read & ~i_pend_q;
    d_elig  = (d_read | d_write) & ~d_pend_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ST_IDLE) begin
`ifdef BMEM_ARB_RR_EN
      if (i_elig && d_elig) begin
        grant_d = ~last_d_q;
        grant_i = last_d_q;
      end else begin
        grant_d = d_elig;
        grant_i = i_elig;
      end
`else
      grant_d = d_elig;
      grant_i = i_elig & ~d_elig;
`endif
    end

    // A beat whose line matches both pending reads goes to whichever was issued first.
    hit_i   = bmem_rvalid & i_pend_q & (bmem_raddr[31:5] == i_line_q);
    hit_d   = bmem_rvalid & d_pend_q & (bmem_raddr[31:5] == d_line_q);
    route_i = hit_i & (~hit_d | ~d_older_q);
    route_d = hit_d & (~hit_i | d_older_q);
    i_rvalid = route_i;
    d_rvalid = route_d;
    if (bmem_rvalid && !hit_i && !hit_d) err_d = 1'b1;
    if (route_i) begin
      i_cnt_d = i_cnt_q + 1'b1;
      if (i_cnt_q == LAST_BEAT) i_pend_d = 1'b0;
    end
    if (route_d) begin
      d_cnt_d = d_cnt_q + 1'b1;
      if (d_cnt_q == LAST_BEAT) d_pend_d = 1'b0;
    end

    if (state_q == ST_WRITE) begin
      bmem_write = 1'b1;
      bmem_addr  = {waddr_q, 5'b0};
      bmem_wdata = wline_q[BEAT_W*wbeat_q +: BEAT_W];
      if (bmem_ready) begin
        wbeat_d = wbeat_q + 1'b1;
        if (wbeat_q == LAST_BEAT) begin
          d_wdone = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end else if (grant_d) begin
      bmem_addr  = {d_addr[31:5], 5'b0};
      bmem_write = d_write;
      bmem_read  = ~d_write;
      if (d_write) bmem_wdata = d_wdata[BEAT_W-1:0];
      d_accept = bmem_ready;
      if (bmem_ready) begin
`ifdef BMEM_ARB_RR_EN
        last_d_d = 1'b1;
`endif
        if (d_write) begin
          state_d = ST_WRITE;
          wline_d = d_wdata;
          waddr_d = d_addr[31:5];
          wbeat_d = CNT_W'(1);
        end else begin
          d_pend_d  = 1'b1;
          d_line_d  = d_addr[31:5];
          d_cnt_d   = '0;
          d_older_d = ~i_pend_d;
        end
      end
    end else if (grant_i) begin
      bmem_addr = {i_addr[31:5], 5'b0};
      bmem_read = 1'b1;
      i_accept  = bmem_ready;
      if (bmem_ready) begin
`ifdef BMEM_ARB_RR_EN
        last_d_d = 1'b0;
`endif
        i_pend_d  = 1'b1;
        i_line_d  = i_addr[31:5];
        i_cnt_d   = '0;
        d_older_d = d_pend_d;
      end
    end

    if (!rst_n) begin
      i_accept   = 1'b0;
      i_rvalid   = 1'b0;
      i_rdata    = '0;
      d_accept   = 1'b0;
      d_wdone    = 1'b0;
      d_rvalid   = 1'b0;
      d_rdata    = '0;
      bmem_addr  = 32'h0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
      err        = 1'b0;
    end
  end

  // State registers; reset aborts any write or read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      i_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      i_line_q  <= '0;
      d_line_q  <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
      wbeat_q   <= '0;
      wline_q   <= '0;
      waddr_q   <= '0;
      d_older_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef BMEM_ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      i_pend_q  <= i_pend_d;
      d_pend_q  <= d_pend_d;
      i_line_q  <= i_line_d;
      d_line_q  <= d_line_d;
      i_cnt_q   <= i_cnt_d;
      d_cnt_q   <= d_cnt_d;
      wbeat_q   <= wbeat_d;
      wline_q   <= wline_d;
      waddr_q   <= waddr_d;
      d_older_q <= d_older_d;
      err_q     <= err_d;
`ifdef BMEM_ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// tb/tb_bmem_arbiter.sv - directed and randomized checks of bmem_arbiter against a line-level model
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
  logic         i_read, i_accept, i_rvalid;
  logic [63:0]  i_rdata, d_rdata, bmem_wdata, bmem_rdata;
  logic         d_read, d_write, d_accept, d_wdone, d_rvalid;
  logic [255:0] d_wdata;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid, err;

  bmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_accept(i_accept), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata), .d_accept(d_accept),
    .d_wdone(d_wdone), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid), .err(err)
  );

  always #5 clk = ~clk;

  int npass = 0, nfail = 0, ntotal = 0;

  // reference model: per-port pending read, issue time, beats seen; write line in flight
  bit           m_pend [2];
  logic [26:0]  m_line [2];
  int           m_cnt  [2];
  longint       m_issue[2];
  bit           m_err, m_wr, m_last_d;
  logic [255:0] m_wline;
  logic [26:0]  m_waddr;
  int           m_wbeat;
  longint       cyc = 0;

  // memory side: lines issued and not yet fully returned, in issue order
  logic [26:0]  mq[$];
  int           mq_beat = 0;
  bit           from_q = 0;
  logic [63:0]  wd_log[$];

  logic         e_iacc, e_dacc, e_br, e_bw, e_wdone, e_irv, e_drv, e_nohit;
  logic [31:0]  e_addr;
  logic [63:0]  e_wd;
  logic [31:0]  lines[4] = '{32'h1eceb000, 32'h1eceb020, 32'h00001040, 32'h80000000};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '{0, 0}; m_cnt = '{0, 0}; m_err = 0; m_wr = 0; m_last_d = 0; m_wbeat = 0;
    mq.delete(); mq_beat = 0; from_q = 0;
  endtask

  task automatic predict();
    bit ei, ed, pd, pi, mi, md;
    e_iacc = 0; e_dacc = 0; e_br = 0; e_bw = 0; e_wdone = 0; e_addr = 0; e_wd = 0;
    if (m_wr) begin
      e_bw = 1; e_addr = {m_waddr, 5'b0}; e_wd = m_wline[64*m_wbeat +: 64];
      e_wdone = bmem_ready && (m_wbeat == 3);
    end else begin
      ed = (d_read || d_write) && !m_pend[1];
      ei = i_read && !m_pend[0];
`ifdef BMEM_ARB_RR_EN
      pd = ed && (!ei || !m_last_d);
`else
      pd = ed;
`endif
      pi = ei && !pd;
      if (pd) begin
        e_addr = {d_addr[31:5], 5'b0};
        if (d_write) begin e_bw = 1; e_wd = d_wdata[63:0]; end else e_br = 1;
        e_dacc = bmem_ready;
      end else if (pi) begin
        e_addr = {i_addr[31:5], 5'b0}; e_br = 1; e_iacc = bmem_ready;
      end
    end
    mi = bmem_rvalid && m_pend[0] && (m_line[0] == bmem_raddr[31:5]);
    md = bmem_rvalid && m_pend[1] && (m_line[1] == bmem_raddr[31:5]);
    e_irv = mi && (!md || m_issue[0] < m_issue[1]);
    e_drv = md && !e_irv;
    e_nohit = bmem_rvalid && !mi && !md;
  endtask

  // one clock: inputs already applied at negedge; check, clock, update model, drop accepted requests
  task automatic tick();
    #1;
    predict();
    chk("ctrl", {i_accept, d_accept, bmem_read, bmem_write, d_wdone, i_rvalid, d_rvalid, err},
        {e_iacc, e_dacc, e_br, e_bw, e_wdone, e_irv, e_drv, m_err});
    chk("bmem_addr", bmem_addr, e_addr);
    chk("bmem_wdata", bmem_wdata, e_wd);
    chk("rdata", {i_rdata, d_rdata}, {bmem_rdata, bmem_rdata});
    if (bmem_write) wd_log.push_back(bmem_wdata);
    @(posedge clk);
    for (int p = 0; p < 2; p++)
      if (p == 0 ? e_irv : e_drv) begin
        m_cnt[p]++;
        if (m_cnt[p] == 4) m_pend[p] = 0;
      end
    if (e_nohit) m_err = 1;
    if (m_wr && bmem_ready) begin
      if (m_wbeat == 3) m_wr = 0; else m_wbeat++;
    end
    if (e_iacc) begin
      m_pend[0] = 1; m_line[0] = i_addr[31:5]; m_cnt[0] = 0; m_issue[0] = cyc;
      mq.push_back(i_addr[31:5]); m_last_d = 0;
    end
    if (e_dacc) begin
      m_last_d = 1;
      if (d_write) begin
        m_wr = 1; m_wline = d_wdata; m_waddr = d_addr[31:5]; m_wbeat = 1;
      end else begin
        m_pend[1] = 1; m_line[1] = d_addr[31:5]; m_cnt[1] = 0; m_issue[1] = cyc;
        mq.push_back(d_addr[31:5]);
      end
    end
    if (from_q && bmem_rvalid) begin
      mq_beat++;
      if (mq_beat == 4) begin void'(mq.pop_front()); mq_beat = 0; end
    end
    cyc++;
    @(negedge clk);
    if (e_iacc) i_read = 0;
    if (e_dacc) begin d_read = 0; d_write = 0; end
  endtask

  task automatic mem_drive(input int pct);
    if (mq.size() > 0 && $urandom_range(99) < pct) begin
      bmem_rvalid = 1; from_q = 1;
      bmem_raddr = {mq[0], mq_beat[1:0], 3'b000};
    end else begin
      bmem_rvalid = 0; from_q = 0; bmem_raddr = $urandom;
    end
    bmem_rdata = {$urandom, $urandom};
  endtask

  task automatic rand_line(output logic [31:0] a);
    a = lines[$urandom_range(3)] | 32'($urandom_range(31));
  endtask

  initial begin
    int drained;
    logic [63:0] wexp[5] = '{64'h1, 64'h2, 64'h2, 64'h3, 64'h4};
    rst_n = 0; i_read = 1; d_read = 0; d_write = 0; i_addr = 32'h1eceb000; d_addr = 0;
    d_wdata = 0; bmem_ready = 1; bmem_rvalid = 1; bmem_raddr = 0; bmem_rdata = 64'hfeed;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {i_accept, i_rvalid, i_rdata, d_accept, d_wdone, d_rvalid, d_rdata,
        bmem_addr, bmem_read, bmem_write, bmem_wdata, err}, '0);
    i_read = 0; bmem_rvalid = 0;
    @(negedge clk);
    rst_n = 1;
    tick();

    // I read, four beats back
    i_read = 1; i_addr = 32'h1eceb000; bmem_ready = 1;
    tick();
    repeat (4) begin mem_drive(100); tick(); end
    chk("i_done_pending", m_pend[0], 0);
    bmem_rvalid = 0;

    // D write with ready low on the second beat
    wd_log.delete();
    d_write = 1; d_addr = 32'h00001040;
    d_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
    tick();
    bmem_ready = 0; tick();
    bmem_ready = 1; repeat (3) tick();
    chk("wseq_len", wd_log.size(), 5);
    for (int k = 0; k < 5; k++) chk("wseq_beat", (k < wd_log.size()) ? wd_log[k] : 64'hx, wexp[k]);

    // I and D read contest in the same cycle
    i_read = 1; i_addr = 32'h80000000; d_read = 1; d_addr = 32'h1eceb040;
    #1;
`ifdef BMEM_ARB_RR_EN
    chk("contest", {i_accept, d_accept}, m_last_d ? 2'b10 : 2'b01);
`else
    chk("contest", {i_accept, d_accept}, 2'b01);
`endif
    tick(); tick();
    repeat (8) begin mem_drive(100); tick(); end
    bmem_rvalid = 0;

    // I then D on the same line: first four beats to I, next four to D
    i_read = 1; i_addr = 32'h1eceb020; tick();
    d_read = 1; d_addr = 32'h1eceb020; tick();
    repeat (8) begin mem_drive(100); tick(); end
    bmem_rvalid = 0;
    chk("same_line_err", err, 0);

    // randomized traffic
    repeat (1500) begin
      if (!i_read && $urandom_range(3) == 0) begin i_read = 1; rand_line(i_addr); end
      if (!d_read && !d_write && $urandom_range(3) == 0) begin
        rand_line(d_addr);
        for (int k = 0; k < 8; k++) d_wdata[32*k +: 32] = $urandom;
        if ($urandom_range(2) == 0) d_write = 1; else d_read = 1;
      end
      bmem_ready = ($urandom_range(3) != 0);
      mem_drive(50);
      tick();
    end

    // drain outstanding traffic within a bounded budget
    drained = 0;
    bmem_ready = 1;
    for (int c = 0; c < 200 && !drained; c++) begin
      if (mq.size() == 0 && !m_wr && !i_read && !d_read && !d_write && !m_pend[0] && !m_pend[1])
        drained = 1;
      else begin mem_drive(100); tick(); end
    end
    chk("drain", drained, 1);
    bmem_rvalid = 0;

    // unmatched response sets sticky err
    bmem_rvalid = 1; bmem_raddr = 32'hdead0000; from_q = 0;
    tick();
    bmem_rvalid = 0;
    chk("err_set", err, 1);
    repeat (3) tick();
    chk("err_sticky", err, 1);

    // reset during write beat 2
    d_write = 1; d_addr = 32'h00001040; d_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
    tick();
    i_read = 1; i_addr = 32'h1eceb000;
    rst_n = 0;
    #1;
    chk("midwrite_reset", {i_accept, i_rvalid, i_rdata, d_accept, d_wdone, d_rvalid, d_rdata,
        bmem_addr, bmem_read, bmem_write, bmem_wdata, err}, '0);
    model_reset();
    @(negedge clk);
    i_read = 0; d_write = 0; rst_n = 1;
    tick();
    chk("post_reset_err", err, 0);
    bmem_rvalid = 1; bmem_raddr = 32'h00001040; from_q = 0;
    tick();
    bmem_rvalid = 0;
    tick();
    chk("stale_beat_err", err, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
